// File: rtl/lockin_pkg.sv
// Shared widths, pairing-state encoding and magnitude helper for the lock-in demodulator.
package lockin_pkg;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } pair_state_e;

    function automatic int prod_w(input int sample_bits, input int ref_bits);
        return sample_bits + ref_bits;
    endfunction

    function automatic int acc_w(input int sample_bits, input int ref_bits, input int int_log2);
        return sample_bits + ref_bits + int_log2;
    endfunction

    // Alpha-max-beta-min with alpha=1, beta=1/2; one spare bit so the caller can saturate.
    function automatic logic [64:0] mag_approx(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] hi;
        logic [63:0] lo;
        hi = (a > b) ? a : b;
        lo = (a > b) ? b : a;
        return {1'b0, hi} + {2'b00, lo[63:1]};
    endfunction

endpackage

// File: rtl/lockin_mac.sv
// One demodulation arm: registered full-width multiply, integrate-and-dump accumulator, floor truncation.
module lockin_mac
    import lockin_pkg::*;
#(
    parameter int SAMPLE_BITS = 24,
    parameter int REF_BITS    = 18,
    parameter int INT_LOG2    = 10,
    parameter int OUT_BITS    = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              mul_en_i,
    input  logic signed [SAMPLE_BITS-1:0]     sample_i,
    input  logic signed [REF_BITS-1:0]        ref_i,
    input  logic                              acc_en_i,
    input  logic                              dump_i,
    output logic signed [OUT_BITS-1:0]        dump_val_o
);
    localparam int P = prod_w(SAMPLE_BITS, REF_BITS);
    localparam int A = acc_w(SAMPLE_BITS, REF_BITS, INT_LOG2);

    logic signed [P-1:0] prod_p1_q;
    logic signed [A-1:0] acc_q;
    logic signed [A-1:0] acc_sum;

    // Stage 1: product of the pair formed this cycle.
    always_ff @(posedge clk) begin
        if (mul_en_i) begin
            prod_p1_q <= P'(sample_i) * P'(ref_i);
        end
    end

    // Stage 2: integrate; the dump cycle reports acc+prod and restarts from zero.
    assign acc_sum    = acc_q + A'(prod_p1_q);
    assign dump_val_o = acc_sum[A-1 -: OUT_BITS];

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else if (acc_en_i) begin
            acc_q <= dump_i ? '0 : acc_sum;
        end
    end

endmodule

// File: rtl/lockin_demodulator.sv
// Dual-phase lock-in demodulator: pairs samples with DDFS cos/sin, integrates I/Q per window.
// Optional LOCKIN_MAG_EN adds an alpha-max-beta-min magnitude output registered with I/Q.
module lockin_demodulator
    import lockin_pkg::*;
#(
    parameter int SAMPLE_BITS = 24,
    parameter int REF_BITS    = 18,
    parameter int INT_LOG2    = 10,
    parameter int OUT_BITS    = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sample_valid,
    input  logic signed [SAMPLE_BITS-1:0] sample_in,
    input  logic                          ref_valid,
    input  logic signed [REF_BITS-1:0]    ref_cos,
    input  logic signed [REF_BITS-1:0]    ref_sin,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic signed [OUT_BITS-1:0]    i_out,
    output logic signed [OUT_BITS-1:0]    q_out,
    output logic                          overrun,
    output logic                          orphan_ref
`ifdef LOCKIN_MAG_EN
    ,
    output logic [OUT_BITS-1:0]           mag_out
`endif
);
    pair_state_e                   state_q, state_d;
    logic signed [SAMPLE_BITS-1:0] held_q, held_d;
    logic signed [SAMPLE_BITS-1:0] pair_sample;
    logic                          pair_vld, ovr_set, orph_set;
    logic                          vld_p1_q;
    logic [INT_LOG2-1:0]           cnt_q;
    logic                          dump;
    logic signed [OUT_BITS-1:0]    dump_i, dump_q;
    logic                          out_valid_q, overrun_q, orphan_q;
    logic signed [OUT_BITS-1:0]    i_q, q_q;

    always_comb begin
        state_d     = state_q;
        held_d      = held_q;
        pair_sample = sample_in;
        pair_vld    = 1'b0;
        ovr_set     = 1'b0;
        orph_set    = 1'b0;
        case (state_q)
            EMPTY: begin
                if (sample_valid && !ref_valid) begin
                    held_d  = sample_in;
                    state_d = HELD;
                end else if (sample_valid && ref_valid) begin
                    pair_vld = 1'b1;
                end else if (ref_valid) begin
                    orph_set = 1'b1;
                end
            end
            HELD: begin
                if (ref_valid) begin
                    pair_vld    = 1'b1;
                    pair_sample = held_q;
                    if (sample_valid) begin
                        held_d = sample_in;
                    end else begin
                        state_d = EMPTY;
                    end
                end else if (sample_valid) begin
                    held_d  = sample_in;
                    ovr_set = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        held_q <= held_d;
    end

    lockin_mac #(
        .SAMPLE_BITS(SAMPLE_BITS), .REF_BITS(REF_BITS), .INT_LOG2(INT_LOG2), .OUT_BITS(OUT_BITS)
    ) u_mac_i (
        .clk(clk), .reset(reset), .mul_en_i(pair_vld), .sample_i(pair_sample), .ref_i(ref_cos),
        .acc_en_i(vld_p1_q), .dump_i(dump), .dump_val_o(dump_i)
    );

    lockin_mac #(
        .SAMPLE_BITS(SAMPLE_BITS), .REF_BITS(REF_BITS), .INT_LOG2(INT_LOG2), .OUT_BITS(OUT_BITS)
    ) u_mac_q (
        .clk(clk), .reset(reset), .mul_en_i(pair_vld), .sample_i(pair_sample), .ref_i(ref_sin),
        .acc_en_i(vld_p1_q), .dump_i(dump), .dump_val_o(dump_q)
    );

    // Stage 2 boundary: the last pair of a window dumps straight into the output register.
    assign dump = vld_p1_q && (&cnt_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            vld_p1_q    <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            orphan_q    <= 1'b0;
            i_q         <= '0;
            q_q         <= '0;
        end else begin
            state_q  <= state_d;
            vld_p1_q <= pair_vld;
            if (vld_p1_q) begin
                cnt_q <= cnt_q + INT_LOG2'(1);
            end
            if (dump) begin
                i_q         <= dump_i;
                q_q         <= dump_q;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (ovr_set || (dump && out_valid_q && !out_ready)) begin
                overrun_q <= 1'b1;
            end
            if (orph_set) begin
                orphan_q <= 1'b1;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign i_out      = i_q;
    assign q_out      = q_q;
    assign overrun    = overrun_q;
    assign orphan_ref = orphan_q;

`ifdef LOCKIN_MAG_EN
    logic [OUT_BITS-1:0] mag_q;

    function automatic logic [OUT_BITS-1:0] abs_val(input logic signed [OUT_BITS-1:0] v);
        return v[OUT_BITS-1] ? OUT_BITS'(-v) : OUT_BITS'(v);
    endfunction

    function automatic logic [OUT_BITS-1:0] sat_mag(input logic [64:0] m);
        return (m > 65'({OUT_BITS{1'b1}})) ? {OUT_BITS{1'b1}} : m[OUT_BITS-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            mag_q <= '0;
        end else if (dump) begin
            mag_q <= sat_mag(mag_approx(64'(abs_val(dump_i)), 64'(abs_val(dump_q))));
        end
    end

    assign mag_out = mag_q;
`endif

endmodule
